ifu_ibuf_writer: RTL and testbench

//  Fetch-side producer for the 48-entry instruction buffer. Issues sequential 64-bit fetch requests
//  to the icache, splits each response into 32-bit instructions, and writes one entry per cycle into
//  the ibuffer while honouring ibuf_full. On redirect it restarts at the new PC and drops stale data.

---
 rtl/ifu_ibuf_writer.sv | 158 +++++++++++++++
 tb/tb_ifu_ibuf_writer.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ifu_ibuf_writer.sv
// Fetch-side producer: sequential 64-bit icache fetches split into 32-bit ibuffer entries.
// Optional performance counters when IFU_IBUF_WRITER_PERF_EN is defined.
module ifu_ibuf_writer #(
    parameter logic [63:0] BOOT_PC = 64'h8000_0000,
    parameter int unsigned SEQ_W   = 32
) (
    input  logic                clock,
    input  logic                reset_n,
    input  logic                redirect_valid,
    input  logic [63:0]         redirect_target,
    output logic                fetch_req_valid,
    input  logic                fetch_req_ready,
    output logic [63:0]         fetch_req_pc,
    input  logic                fetch_resp_valid,
    input  logic [63:0]         fetch_resp_data,
    input  logic                fetch_resp_fault,
    input  logic                ibuf_full,
    output logic                ibuf_write_en,
    output logic [97+SEQ_W-1:0] ibuf_data,
    output logic                fetch_halted
`ifdef IFU_IBUF_WRITER_PERF_EN
    ,
    output logic [31:0]         perf_push_cnt,
    output logic [31:0]         perf_full_stall_cnt
`endif
);

    typedef enum logic [2:0] {
        S_REQ, S_WAIT, S_WAIT_DROP, S_PUSH_LO, S_PUSH_HI, S_HALT
    } state_t;

    state_t                state;
    logic [63:0]           fetch_pc;
    logic [SEQ_W-1:0]      seq;
    logic                  req_valid_q;
    logic                  wr_q;
    logic [97+SEQ_W-1:0]   data_q;
    logic [31:0]           hold_hi;
    logic                  hold_fault;
    logic                  halted_q;
    logic [63:0]           blk;
    logic                  handshake;

    assign blk             = {fetch_pc[63:3], 3'b000};
    assign handshake       = req_valid_q & fetch_req_ready;
    assign fetch_req_valid = req_valid_q;
    assign fetch_req_pc    = blk;
    // Registered strobe gated so a write never lands while full or during a redirect.
    assign ibuf_write_en   = wr_q & ~ibuf_full & ~redirect_valid;
    assign ibuf_data       = data_q;
    assign fetch_halted    = halted_q;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state       <= S_REQ;
            fetch_pc    <= BOOT_PC;
            seq         <= '0;
            req_valid_q <= 1'b0;
            wr_q        <= 1'b0;
            data_q      <= '0;
            hold_hi     <= '0;
            hold_fault  <= 1'b0;
            halted_q    <= 1'b0;
        end else if (redirect_valid) begin
            fetch_pc   <= redirect_target;
            seq        <= seq + 1'b1;
            wr_q       <= 1'b0;
            hold_hi    <= '0;
            hold_fault <= 1'b0;
            halted_q   <= 1'b0;
            // A request still owed a response must have that response swallowed first.
            if ((state == S_REQ && handshake) ||
                ((state == S_WAIT || state == S_WAIT_DROP) && !fetch_resp_valid)) begin
                state       <= S_WAIT_DROP;
                req_valid_q <= 1'b0;
            end else begin
                state       <= S_REQ;
                req_valid_q <= 1'b1;
            end
        end else begin
            case (state)
                S_REQ: begin
                    if (handshake) begin
                        state       <= S_WAIT;
                        req_valid_q <= 1'b0;
                    end else begin
                        req_valid_q <= 1'b1;
                    end
                end
                S_WAIT: begin
                    if (fetch_resp_valid) begin
                        hold_hi    <= fetch_resp_data[63:32];
                        hold_fault <= fetch_resp_fault;
                        wr_q       <= 1'b1;
                        state      <= fetch_pc[2] ? S_PUSH_HI : S_PUSH_LO;
                        if (fetch_resp_fault)
                            data_q <= {1'b1, 32'h0, seq, fetch_pc};
                        else if (!fetch_pc[2])
                            data_q <= {1'b0, fetch_resp_data[31:0], seq, blk};
                        else
                            data_q <= {1'b0, fetch_resp_data[63:32], seq, blk | 64'd4};
                    end
                end
                S_WAIT_DROP: begin
                    if (fetch_resp_valid) begin
                        state       <= S_REQ;
                        req_valid_q <= 1'b1;
                    end
                end
                S_PUSH_LO: begin
                    if (!ibuf_full) begin
                        if (hold_fault) begin
                            state    <= S_HALT;
                            wr_q     <= 1'b0;
                            halted_q <= 1'b1;
                        end else begin
                            data_q <= {1'b0, hold_hi, seq, blk | 64'd4};
                            state  <= S_PUSH_HI;
                        end
                    end
                end
                S_PUSH_HI: begin
                    if (!ibuf_full) begin
                        wr_q <= 1'b0;
                        if (hold_fault) begin
                            state    <= S_HALT;
                            halted_q <= 1'b1;
                        end else begin
                            fetch_pc    <= blk + 64'd8;
                            seq         <= seq + 1'b1;
                            state       <= S_REQ;
                            req_valid_q <= 1'b1;
                        end
                    end
                end
                S_HALT: begin
                    req_valid_q <= 1'b0;
                end
                default: state <= S_REQ;
            endcase
        end
    end

`ifdef IFU_IBUF_WRITER_PERF_EN
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            perf_push_cnt       <= '0;
            perf_full_stall_cnt <= '0;
        end else begin
            if (ibuf_write_en)
                perf_push_cnt <= perf_push_cnt + 32'd1;
            if ((state == S_PUSH_LO || state == S_PUSH_HI) && ibuf_full)
                perf_full_stall_cnt <= perf_full_stall_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_ifu_ibuf_writer.sv
// Directed self-checking bench for ifu_ibuf_writer (SEQ_W=4 so the tag wrap is reachable).
module tb_ifu_ibuf_writer;

    logic         clock;
    logic         reset_n;
    logic         redirect_valid;
    logic [63:0]  redirect_target;
    logic         fetch_req_valid;
    logic         fetch_req_ready;
    logic [63:0]  fetch_req_pc;
    logic         fetch_resp_valid;
    logic [63:0]  fetch_resp_data;
    logic         fetch_resp_fault;
    logic         ibuf_full;
    logic         ibuf_write_en;
    logic [100:0] ibuf_data;
    logic         fetch_halted;
`ifdef IFU_IBUF_WRITER_PERF_EN
    logic [31:0]  perf_push_cnt;
    logic [31:0]  perf_full_stall_cnt;
`endif

    int checks = 0;
    int errors = 0;

    ifu_ibuf_writer #(.BOOT_PC(64'h8000_0000), .SEQ_W(4)) dut (
        .clock(clock), .reset_n(reset_n),
        .redirect_valid(redirect_valid), .redirect_target(redirect_target),
        .fetch_req_valid(fetch_req_valid), .fetch_req_ready(fetch_req_ready),
        .fetch_req_pc(fetch_req_pc),
        .fetch_resp_valid(fetch_resp_valid), .fetch_resp_data(fetch_resp_data),
        .fetch_resp_fault(fetch_resp_fault),
        .ibuf_full(ibuf_full), .ibuf_write_en(ibuf_write_en), .ibuf_data(ibuf_data),
        .fetch_halted(fetch_halted)
`ifdef IFU_IBUF_WRITER_PERF_EN
        , .perf_push_cnt(perf_push_cnt), .perf_full_stall_cnt(perf_full_stall_cnt)
`endif
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic chk(input string tag, input logic [159:0] obs, input logic [159:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [100:0] ent(input logic f, input logic [31:0] i,
                                         input logic [3:0] s, input logic [63:0] p);
        return {f, i, s, p};
    endfunction

    // Move to 1 time unit after the next rising edge (input-drive phase).
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // One full aligned block fetch; starts and ends in the input-drive phase.
    task automatic block(input logic [63:0] pc, input logic [3:0] sq, input logic [63:0] data);
        int n = 0;
        #1;
        while (!fetch_req_valid && n < 20) begin
            tick();
            #1;
            n++;
        end
        chk("req_valid", {159'd0, fetch_req_valid}, 160'd1);
        chk("req_pc", {96'd0, fetch_req_pc}, {96'd0, pc});
        fetch_req_ready = 1'b1;
        tick();
        fetch_req_ready  = 1'b0;
        fetch_resp_valid = 1'b1;
        fetch_resp_data  = data;
        #1;
        chk("we_in_wait", {159'd0, ibuf_write_en}, 160'd0);
        tick();
        fetch_resp_valid = 1'b0;
        #1;
        chk("we_lo", {159'd0, ibuf_write_en}, 160'd1);
        chk("data_lo", {59'd0, ibuf_data}, {59'd0, ent(1'b0, data[31:0], sq, pc)});
        tick();
        #1;
        chk("we_hi", {159'd0, ibuf_write_en}, 160'd1);
        chk("data_hi", {59'd0, ibuf_data}, {59'd0, ent(1'b0, data[63:32], sq, pc | 64'd4)});
        tick();
    endtask

    initial begin
        logic [100:0] held;
        reset_n          = 1'b0;
        redirect_valid   = 1'b1;
        redirect_target  = 64'h4444;
        fetch_req_ready  = 1'b0;
        fetch_resp_valid = 1'b0;
        fetch_resp_data  = '0;
        fetch_resp_fault = 1'b0;
        ibuf_full        = 1'b0;

        // Reset state, with a redirect that must be ignored
        tick(); tick();
        chk("rst_req_valid", {159'd0, fetch_req_valid}, 160'd0);
        chk("rst_req_pc", {96'd0, fetch_req_pc}, {96'd0, 64'h8000_0000});
        chk("rst_we", {159'd0, ibuf_write_en}, 160'd0);
        chk("rst_data", {59'd0, ibuf_data}, 160'd0);
        chk("rst_halted", {159'd0, fetch_halted}, 160'd0);
        reset_n        = 1'b1;
        redirect_valid = 1'b0;

        // 1: first block from BOOT_PC
        block(64'h8000_0000, 4'd0, 64'h00000013_00000093);
        #1;
        chk("t1_next_pc", {96'd0, fetch_req_pc}, {96'd0, 64'h8000_0008});

        // 2: redirect to an odd-word target -> single high-word write
        redirect_valid  = 1'b1;
        redirect_target = 64'h1004;
        #1;
        chk("t2_we_redirect", {159'd0, ibuf_write_en}, 160'd0);
        tick();
        redirect_valid = 1'b0;
        #1;
        chk("t2_req_valid", {159'd0, fetch_req_valid}, 160'd1);
        chk("t2_req_pc", {96'd0, fetch_req_pc}, {96'd0, 64'h1000});
        fetch_req_ready = 1'b1;
        tick();
        fetch_req_ready  = 1'b0;
        fetch_resp_valid = 1'b1;
        fetch_resp_data  = 64'hAAAABBBB_CCCCDDDD;
        tick();
        fetch_resp_valid = 1'b0;
        #1;
        chk("t2_we", {159'd0, ibuf_write_en}, 160'd1);
        chk("t2_data", {59'd0, ibuf_data}, {59'd0, ent(1'b0, 32'hAAAABBBB, 4'd2, 64'h1004)});
        tick();
        #1;
        chk("t2_we_after", {159'd0, ibuf_write_en}, 160'd0);
        chk("t2_next_pc", {96'd0, fetch_req_pc}, {96'd0, 64'h1008});

        // 3: ibuf_full held for 10 cycles in PUSH_LO
        fetch_req_ready = 1'b1;
        tick();
        fetch_req_ready  = 1'b0;
        fetch_resp_valid = 1'b1;
        fetch_resp_data  = 64'h22222222_11111111;
        tick();
        fetch_resp_valid = 1'b0;
        ibuf_full        = 1'b1;
        held = ent(1'b0, 32'h11111111, 4'd3, 64'h1008);
        for (int i = 0; i < 10; i++) begin
            #1;
            chk("t3_we_full", {159'd0, ibuf_write_en}, 160'd0);
            chk("t3_data_stable", {59'd0, ibuf_data}, {59'd0, held});
            tick();
        end
        ibuf_full = 1'b0;
        #1;
        chk("t3_we_lo", {159'd0, ibuf_write_en}, 160'd1);
        chk("t3_data_lo", {59'd0, ibuf_data}, {59'd0, held});
        tick();
        #1;
        chk("t3_data_hi", {59'd0, ibuf_data}, {59'd0, ent(1'b0, 32'h22222222, 4'd3, 64'h100C)});
        tick();
`ifdef IFU_IBUF_WRITER_PERF_EN
        chk("t3_perf_stall", {128'd0, perf_full_stall_cnt}, 160'd10);
        chk("t3_perf_push", {128'd0, perf_push_cnt}, 160'd5);
`endif

        // 4: redirect while waiting -> late response dropped
        #1;
        chk("t4_req_pc", {96'd0, fetch_req_pc}, {96'd0, 64'h1010});
        fetch_req_ready = 1'b1;
        tick();
        fetch_req_ready = 1'b0;
        redirect_valid  = 1'b1;
        redirect_target = 64'h2000;
        tick();
        redirect_valid = 1'b0;
        #1;
        chk("t4_no_req_drop", {159'd0, fetch_req_valid}, 160'd0);
        fetch_resp_valid = 1'b1;
        fetch_resp_data  = 64'hDEADDEAD_BEEFBEEF;
        tick();
        fetch_resp_valid = 1'b0;
        #1;
        chk("t4_we_dropped", {159'd0, ibuf_write_en}, 160'd0);
        chk("t4_req_valid", {159'd0, fetch_req_valid}, 160'd1);
        chk("t4_req_pc_tgt", {96'd0, fetch_req_pc}, {96'd0, 64'h2000});

        // 5: access fault -> one fault entry, then halt until redirect
        fetch_req_ready = 1'b1;
        tick();
        fetch_req_ready  = 1'b0;
        fetch_resp_valid = 1'b1;
        fetch_resp_fault = 1'b1;
        fetch_resp_data  = 64'h12345678_9ABCDEF0;
        tick();
        fetch_resp_valid = 1'b0;
        fetch_resp_fault = 1'b0;
        #1;
        chk("t5_we", {159'd0, ibuf_write_en}, 160'd1);
        chk("t5_data", {59'd0, ibuf_data}, {59'd0, ent(1'b1, 32'h0, 4'd5, 64'h2000)});
        for (int i = 0; i < 4; i++) begin
            tick();
            #1;
            chk("t5_halted", {159'd0, fetch_halted}, 160'd1);
            chk("t5_no_req", {159'd0, fetch_req_valid}, 160'd0);
            chk("t5_no_we", {159'd0, ibuf_write_en}, 160'd0);
        end
        redirect_valid  = 1'b1;
        redirect_target = 64'h3000;
        tick();
        redirect_valid = 1'b0;
        #1;
        chk("t5_unhalted", {159'd0, fetch_halted}, 160'd0);
        chk("t5_req_pc", {96'd0, fetch_req_pc}, {96'd0, 64'h3000});
        tick();

        // 6: sequence tag wraps 15 -> 0
        for (int i = 0; i < 12; i++) begin
            logic [3:0] s;
            s = 4'(6 + i);
            block(64'h3000 + 64'(8 * i), s, {32'(i) + 32'h1000, 32'(i)});
        end

        // reset in the middle of PUSH_HI
        #1;
        chk("t6_req_pc", {96'd0, fetch_req_pc}, {96'd0, 64'h3060});
        fetch_req_ready = 1'b1;
        tick();
        fetch_req_ready  = 1'b0;
        fetch_resp_valid = 1'b1;
        fetch_resp_data  = 64'h55555555_66666666;
        tick();
        fetch_resp_valid = 1'b0;
        tick();
        reset_n = 1'b0;
        #1;
        chk("t6_rst_we", {159'd0, ibuf_write_en}, 160'd0);
        chk("t6_rst_data", {59'd0, ibuf_data}, 160'd0);
        chk("t6_rst_req", {159'd0, fetch_req_valid}, 160'd0);
        chk("t6_rst_pc", {96'd0, fetch_req_pc}, {96'd0, 64'h8000_0000});
        tick();
        reset_n = 1'b1;
        block(64'h8000_0000, 4'd0, 64'h77777777_88888888);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
